// File: rtl/mac_chk_pkg.sv
// Shared types and fp32 field helpers for the MAC result checker.
// Contents: chk_state_t (checker FSM states), fp32 field positions,
// fp32_is_nan() used by the tolerant compare.
package mac_chk_pkg;

    localparam int unsigned FP32_W       = 32;
    localparam int unsigned FP32_EXP_MSB = 30;
    localparam int unsigned FP32_EXP_LSB = 23;
    localparam logic [7:0]  FP32_NAN_EXP = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic fp32_is_nan(input logic [FP32_W-1:0] w);
        return (w[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_NAN_EXP) &&
               (w[FP32_EXP_LSB-1:0] != '0);
    endfunction

endpackage

// File: rtl/mac_chk_fifo.sv
// Expected-word FIFO: DEPTH x 32 synchronous FIFO with wrap-bit pointers.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the FIFO)
//   clr_i          synchronous flush (start of a new run)
//   push_i/data_i  write request; taken when not full, or when full with a pop
//   pop_i          read request; taken when not empty
//   head_o         word at the head (combinational read)
//   full_o/empty_o/count_o  occupancy status
// DEPTH must be a power of two and at least 2.
module mac_chk_fifo
    import mac_chk_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [FP32_W-1:0] data_i,
    input  logic              pop_i,
    output logic [FP32_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);

    logic [FP32_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              do_wr;
    logic              do_rd;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so push-at-full with pop is legal.
    assign do_rd = pop_i && !empty_o;
    assign do_wr = push_i && (!full_o || do_rd);

    // Pointer update; flush takes priority over any traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mac_result_checker.sv
// Self-checking back end of the pipelined BF16 MAC bench.
// Streams NUM_VECTORS reads from the vector source, buffers each expected
// fp32 word, compares it against the DUT result as it arrives and reports
// pass/fail counts, the first failure and sticky error flags.
// Ports:
//   clk, RST                 clock, asynchronous active-high reset
//   start                    run request (accepted in IDLE or DONE)
//   rd_en                    vector-source read strobe
//   exp_mac                  expected word, valid the cycle after rd_en
//   dut_valid, dut_mac       DUT result
//   busy, done               run status
//   pass_cnt, fail_cnt       saturating compare counters
//   first_fail_idx/_got      index and DUT word of first failure
//   ovf, unf, tmo            sticky FIFO overflow / underflow / drain timeout
// Build option: define MAC_CHK_ULP_TOL_EN for NaN-aware compare with ULP_TOL
// magnitude tolerance; otherwise compare is exact bitwise.
module mac_result_checker
    import mac_chk_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 1000,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned ULP_TOL     = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    output logic              rd_en,
    input  logic [FP32_W-1:0] exp_mac,
    input  logic              dut_valid,
    input  logic [FP32_W-1:0] dut_mac,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [FP32_W-1:0] first_fail_got,
    output logic              ovf,
    output logic              unf,
    output logic              tmo
);

    localparam int unsigned ISS_W  = $clog2(NUM_VECTORS + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam int unsigned FAW    = $clog2(DEPTH);
    localparam int unsigned MAG_W  = FP32_W - 1;

    chk_state_t        state_q;
    logic              rd_en_q;
    logic              exp_valid_q;
    logic [ISS_W-1:0]  issue_q;
    logic [CNT_W-1:0]  cmp_cnt_q;
    logic [IDLE_W-1:0] idle_q;
    logic [CNT_W-1:0]  pass_q;
    logic [CNT_W-1:0]  fail_q;
    logic              ff_seen_q;
    logic [CNT_W-1:0]  ff_idx_q;
    logic [FP32_W-1:0] ff_got_q;
    logic              ovf_q;
    logic              unf_q;
    logic              tmo_q;
    logic              busy_q;
    logic              done_q;

    logic              fifo_clr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FP32_W-1:0] fifo_head;
    logic [FAW:0]      fifo_count_unused;

    logic              active;
    logic              pop_req;
    logic              push_drop;
    logic              match;
    logic [CNT_W-1:0]  cmp_next;
    logic [IDLE_W-1:0] idle_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Result ports are straight register copies.
    assign rd_en          = rd_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_got = ff_got_q;
    assign ovf            = ovf_q;
    assign unf            = unf_q;
    assign tmo            = tmo_q;

    // dut_valid only counts while a run is in flight.
    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign pop_req   = dut_valid && active;
    assign push_drop = exp_valid_q && fifo_full && !pop_req;
    assign cmp_next  = pop_req ? sat_inc(cmp_cnt_q) : cmp_cnt_q;
    assign idle_next = idle_q + IDLE_W'(1);
    // Leftover words from an aborted or short run must not leak into the next one.
    assign fifo_clr  = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef MAC_CHK_ULP_TOL_EN
    logic [MAG_W-1:0] mag_diff;
    logic             dut_nan;
    logic             head_nan;

    // Same-sign magnitudes are monotonic in the raw bits, so the ULP distance is a subtraction.
    always_comb begin
        dut_nan  = fp32_is_nan(dut_mac);
        head_nan = fp32_is_nan(fifo_head);
        mag_diff = (dut_mac[MAG_W-1:0] >= fifo_head[MAG_W-1:0]) ?
                   (dut_mac[MAG_W-1:0] - fifo_head[MAG_W-1:0]) :
                   (fifo_head[MAG_W-1:0] - dut_mac[MAG_W-1:0]);
        match    = (dut_mac == fifo_head) ||
                   (dut_nan && head_nan) ||
                   ((dut_mac[FP32_W-1] == fifo_head[FP32_W-1]) && !dut_nan && !head_nan &&
                    (mag_diff <= MAG_W'(ULP_TOL)));
    end
`else
    logic ulp_tol_unused;

    // Tolerance only matters for the tolerant-compare build.
    assign ulp_tol_unused = (ULP_TOL != 0);
    assign match          = (dut_mac == fifo_head);
`endif

    mac_chk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (RST),
        .clr_i   (fifo_clr),
        .push_i  (exp_valid_q),
        .data_i  (exp_mac),
        .pop_i   (pop_req),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    // Run control, compare bookkeeping and result registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            exp_valid_q <= 1'b0;
            issue_q     <= '0;
            cmp_cnt_q   <= '0;
            idle_q      <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            ff_seen_q   <= 1'b0;
            ff_idx_q    <= '1;
            ff_got_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            exp_valid_q <= rd_en_q;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= RUN;
                        rd_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        issue_q   <= '0;
                        cmp_cnt_q <= '0;
                        idle_q    <= '0;
                        pass_q    <= '0;
                        fail_q    <= '0;
                        ff_seen_q <= 1'b0;
                        ff_idx_q  <= '1;
                        ff_got_q  <= '0;
                        ovf_q     <= 1'b0;
                        unf_q     <= 1'b0;
                        tmo_q     <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (pop_req) begin
                        cmp_cnt_q <= cmp_next;
                        idle_q    <= '0;
                        if (!fifo_empty && match) begin
                            pass_q <= sat_inc(pass_q);
                        end else begin
                            fail_q <= sat_inc(fail_q);
                            if (!ff_seen_q) begin
                                ff_seen_q <= 1'b1;
                                ff_idx_q  <= cmp_cnt_q;
                                ff_got_q  <= dut_mac;
                            end
                        end
                        if (fifo_empty) unf_q <= 1'b1;
                    end else if (state_q == DRAIN) begin
                        idle_q <= idle_next;
                    end
                    if (push_drop) ovf_q <= 1'b1;

                    if (state_q == RUN) begin
                        // Strobe stays high for exactly NUM_VECTORS cycles.
                        if (issue_q == ISS_W'(NUM_VECTORS - 1)) begin
                            state_q <= DRAIN;
                            rd_en_q <= 1'b0;
                        end else begin
                            issue_q <= issue_q + ISS_W'(1);
                        end
                    end else if (cmp_next == CNT_W'(NUM_VECTORS)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!pop_req && (idle_next == IDLE_W'(TIMEOUT))) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_result_checker.sv
// Bench for mac_result_checker: two instances (4 vectors / depth 8, and
// 8 vectors / depth 4 for overflow), a vector-source model, a fixed-latency
// DUT model, and a queue of expected run results popped at each done.
module tb_mac_result_checker;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMO   = 16;

    typedef struct packed {
        logic [15:0] pass;
        logic [15:0] fail;
        logic [15:0] idx;
        logic [31:0] got;
        logic        ovf;
        logic        unf;
        logic        tmo;
    } res_t;

    logic             clk;
    logic             RST;
    logic             start_s  [2];
    logic             rd_en_s  [2];
    logic [31:0]      exp_s    [2];
    logic             dv_s     [2];
    logic [31:0]      dmac_s   [2];
    logic             busy_s   [2];
    logic             done_s   [2];
    logic [CNT_W-1:0] pass_s   [2];
    logic [CNT_W-1:0] fail_s   [2];
    logic [CNT_W-1:0] idx_s    [2];
    logic [31:0]      got_s    [2];
    logic             ovf_s    [2];
    logic             unf_s    [2];
    logic             tmo_s    [2];

    logic [31:0] vec_exp [2][16];
    logic [31:0] vec_dut [2][16];
    logic [3:0]  lat     [2];
    logic [4:0]  limit   [2];
    logic        pv      [2][16];
    logic [3:0]  pi      [2][16];
    logic [3:0]  src_idx [2];
    logic        inj_v;
    logic [31:0] inj_w;

    res_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mac_result_checker #(
        .NUM_VECTORS (4), .DEPTH (8), .CNT_W (CNT_W), .TIMEOUT (TMO), .ULP_TOL (1)
    ) u_dut0 (
        .clk (clk), .RST (RST), .start (start_s[0]), .rd_en (rd_en_s[0]),
        .exp_mac (exp_s[0]), .dut_valid (dv_s[0]), .dut_mac (dmac_s[0]),
        .busy (busy_s[0]), .done (done_s[0]), .pass_cnt (pass_s[0]), .fail_cnt (fail_s[0]),
        .first_fail_idx (idx_s[0]), .first_fail_got (got_s[0]),
        .ovf (ovf_s[0]), .unf (unf_s[0]), .tmo (tmo_s[0])
    );

    mac_result_checker #(
        .NUM_VECTORS (8), .DEPTH (4), .CNT_W (CNT_W), .TIMEOUT (TMO), .ULP_TOL (1)
    ) u_dut1 (
        .clk (clk), .RST (RST), .start (start_s[1]), .rd_en (rd_en_s[1]),
        .exp_mac (exp_s[1]), .dut_valid (dv_s[1]), .dut_mac (dmac_s[1]),
        .busy (busy_s[1]), .done (done_s[1]), .pass_cnt (pass_s[1]), .fail_cnt (fail_s[1]),
        .first_fail_idx (idx_s[1]), .first_fail_got (got_s[1]),
        .ovf (ovf_s[1]), .unf (unf_s[1]), .tmo (tmo_s[1])
    );

    // Vector source (index restarts when read drops) and DUT latency pipe.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (RST) begin
                src_idx[n] <= 4'd0;
                exp_s[n]   <= 32'd0;
                for (int j = 0; j < 16; j++) begin
                    pv[n][j] <= 1'b0;
                    pi[n][j] <= 4'd0;
                end
            end else begin
                if (rd_en_s[n]) begin
                    exp_s[n]   <= vec_exp[n][src_idx[n]];
                    src_idx[n] <= src_idx[n] + 4'd1;
                end else begin
                    src_idx[n] <= 4'd0;
                end
                pv[n][0] <= rd_en_s[n];
                pi[n][0] <= src_idx[n];
                for (int j = 1; j < 16; j++) begin
                    pv[n][j] <= pv[n][j-1];
                    pi[n][j] <= pi[n][j-1];
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            dv_s[n]   = pv[n][lat[n] - 4'd1] && ({1'b0, pi[n][lat[n] - 4'd1]} < limit[n]);
            dmac_s[n] = vec_dut[n][pi[n][lat[n] - 4'd1]];
        end
        if (inj_v) begin
            dv_s[0]   = 1'b1;
            dmac_s[0] = inj_w;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_res(input int n, input string tag, input res_t e);
        check({tag, "_pass"}, 32'(pass_s[n]), 32'(e.pass));
        check({tag, "_fail"}, 32'(fail_s[n]), 32'(e.fail));
        check({tag, "_idx"},  32'(idx_s[n]),  32'(e.idx));
        check({tag, "_got"},  got_s[n],       e.got);
        check({tag, "_ovf"},  32'(ovf_s[n]),  32'(e.ovf));
        check({tag, "_unf"},  32'(unf_s[n]),  32'(e.unf));
        check({tag, "_tmo"},  32'(tmo_s[n]),  32'(e.tmo));
    endtask

    // Called at #1 after an edge; leaves the DUT having sampled start.
    task automatic pulse_start(input int n);
        start_s[n] = 1'b1;
        @(posedge clk); #1;
        start_s[n] = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // One run: expectation queued at stimulus time, popped and compared at done.
    task automatic run(input int n, input string tag, input res_t e, input bit inj,
                       output int rd_cycles, output int last_v, output int tmo_at);
        int   k;
        logic v_now;
        logic r_now;
        res_t want;
        exp_q.push_back(e);
        pulse_start(n);
        if (inj) begin
            inj_v = 1'b1;
            inj_w = 32'hDEAD_BEEF;
        end
        check({tag, "_busy"}, 32'(busy_s[n]), 32'd1);
        k = 0; rd_cycles = 0; last_v = -1; tmo_at = -1;
        while (done_s[n] !== 1'b1 && k < 200) begin
            v_now = dv_s[n];
            r_now = rd_en_s[n];
            @(posedge clk); #1;
            k++;
            inj_v = 1'b0;
            if (r_now) rd_cycles++;
            if (v_now) last_v = k;
            if (tmo_s[n] && tmo_at < 0) tmo_at = k;
        end
        check({tag, "_done"}, 32'(done_s[n]), 32'd1);
        want = exp_q.pop_front();
        check_res(n, tag, want);
        idle(24);
    endtask

    initial begin
        res_t e;
        int   rc, lv, ta;
        RST = 1'b1;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        inj_v = 1'b0; inj_w = 32'd0;
        lat[0] = 4'd3; lat[1] = 4'd6;
        limit[0] = 5'd16; limit[1] = 5'd16;
        for (int i = 0; i < 16; i++) begin
            vec_exp[1][i] = 32'h4000_0000 + (32'(i) << 8);
            vec_dut[1][i] = vec_exp[1][i];
            vec_exp[0][i] = 32'h4100_0000 + (32'(i) << 12);
        end
        vec_exp[0][0] = 32'h4040_0000;
        vec_exp[0][1] = 32'h4080_0000;
        vec_exp[0][2] = 32'h3F80_0000;
        vec_exp[0][3] = 32'hC0A0_0000;
        for (int i = 0; i < 16; i++) vec_dut[0][i] = vec_exp[0][i];
        idle(3);

        // Reset state
        check("rst_rd_en", 32'(rd_en_s[0]), 32'd0);
        check("rst_busy",  32'(busy_s[0]),  32'd0);
        check("rst_done",  32'(done_s[0]),  32'd0);
        check("rst_pass",  32'(pass_s[0]),  32'd0);
        check("rst_fail",  32'(fail_s[0]),  32'd0);
        check("rst_idx",   32'(idx_s[0]),   32'h0000_FFFF);
        check("rst_got",   got_s[0],        32'd0);
        check("rst_flags", {29'd0, ovf_s[0], unf_s[0], tmo_s[0]}, 32'd0);
        check("rst_idx1",  32'(idx_s[1]),   32'h0000_FFFF);
        RST = 1'b0;
        idle(2);

        // 1: clean run
        e = '{pass: 16'd4, fail: 16'd0, idx: 16'hFFFF, got: 32'd0, ovf: 1'b0, unf: 1'b0, tmo: 1'b0};
        run(0, "t1", e, 1'b0, rc, lv, ta);
        check("t1_rd_cycles", 32'(rc), 32'd4);

        // 2: one-ulp error on vector 2
        vec_dut[0][2] = 32'h3F80_0001;
`ifdef MAC_CHK_ULP_TOL_EN
        e = '{pass: 16'd4, fail: 16'd0, idx: 16'hFFFF, got: 32'd0, ovf: 1'b0, unf: 1'b0, tmo: 1'b0};
`else
        e = '{pass: 16'd3, fail: 16'd1, idx: 16'd2, got: 32'h3F80_0001, ovf: 1'b0, unf: 1'b0, tmo: 1'b0};
`endif
        run(0, "t2", e, 1'b0, rc, lv, ta);
        vec_dut[0][2] = vec_exp[0][2];

        // 2b: large error on vector 1 fails in either build
        vec_dut[0][1] = 32'h4090_0000;
        e = '{pass: 16'd3, fail: 16'd1, idx: 16'd1, got: 32'h4090_0000, ovf: 1'b0, unf: 1'b0, tmo: 1'b0};
        run(0, "t2b", e, 1'b0, rc, lv, ta);
        vec_dut[0][1] = vec_exp[0][1];

        // 3: depth 4, latency 6 -> 5th word dropped, later heads shifted, final pop underflows
        e = '{pass: 16'd4, fail: 16'd4, idx: 16'd4, got: 32'h4000_0400, ovf: 1'b1, unf: 1'b1, tmo: 1'b0};
        run(1, "t3", e, 1'b0, rc, lv, ta);
        check("t3_rd_cycles", 32'(rc), 32'd8);

        // 4: stray result one cycle after start with FIFO empty
        e = '{pass: 16'd3, fail: 16'd1, idx: 16'd0, got: 32'hDEAD_BEEF, ovf: 1'b0, unf: 1'b1, tmo: 1'b0};
        run(0, "t4", e, 1'b1, rc, lv, ta);

        // 5: DUT stops after two results -> drain timeout
        limit[0] = 5'd2;
        e = '{pass: 16'd2, fail: 16'd0, idx: 16'hFFFF, got: 32'd0, ovf: 1'b0, unf: 1'b0, tmo: 1'b1};
        run(0, "t5", e, 1'b0, rc, lv, ta);
        check("t5_tmo_delay", 32'(ta - lv), 32'(TMO));
        limit[0] = 5'd16;

        // 6: reset mid-run, then a clean run
        pulse_start(0);
        idle(2);
        check("t6_pre_rd_en", 32'(rd_en_s[0]), 32'd1);
        RST = 1'b1;
        #1;
        check("t6_rd_en", 32'(rd_en_s[0]), 32'd0);
        check("t6_busy",  32'(busy_s[0]),  32'd0);
        check("t6_cnts",  {pass_s[0], fail_s[0]}, 32'd0);
        check("t6_flags", {29'd0, ovf_s[0], unf_s[0], tmo_s[0]}, 32'd0);
        @(posedge clk); #1;
        RST = 1'b0;
        idle(20);
        e = '{pass: 16'd4, fail: 16'd0, idx: 16'hFFFF, got: 32'd0, ovf: 1'b0, unf: 1'b0, tmo: 1'b0};
        run(0, "t6_rerun", e, 1'b0, rc, lv, ta);
        check("t6_rd_cycles", 32'(rc), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
